// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester, register-file write and hazard query signals
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_addr;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_we;
  logic [4:0]           rf_wa;
  logic [31:0]          rf_wd;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic                 issue_ready;
  logic [4:0]           ra_a;
  logic [4:0]           ra_b;
  logic                 busy_a;
  logic                 busy_b;
  logic                 fwd_hit_a;
  logic                 fwd_hit_b;
  logic [31:0]          fwd_data;

  modport master (
    output req_valid, req_addr, req_data, issue_valid, issue_rd, ra_a, ra_b,
    input  req_ready, rf_we, rf_wa, rf_wd, issue_ready, busy_a, busy_b,
           fwd_hit_a, fwd_hit_b, fwd_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, issue_valid, issue_rd, ra_a, ra_b,
    output req_ready, rf_we, rf_wa, rf_wd, issue_ready, busy_a, busy_b,
           fwd_hit_a, fwd_hit_b, fwd_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin register-file writeback arbiter with pending-write scoreboard
// Define WB_FORWARD_EN to forward the in-flight write; otherwise busy clears one cycle later.
module regfile_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PW-1:0] ptr_t;

  ptr_t        rr_ptr_q, rr_ptr_d;
  ptr_t        win_idx, scan_idx;
  logic        xfer;
  logic [NREQ-1:0] grant;
  logic [4:0]  win_addr;
  logic [31:0] win_data;
  logic [4:0]  addr_arr [NREQ];
  logic [31:0] data_arr [NREQ];

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_wa_q, rf_wa_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic [31:0] busy_q, busy_d, set_vec, clr_vec;
  logic        issue_ready;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.req_addr[5*g +: 5];
    assign data_arr[g] = bus.req_data[32*g +: 32];
  end

  // First asserted requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant    = '0;
    xfer     = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = ptr_t'((int'(rr_ptr_q) + k) % NREQ);
      if (!xfer && bus.req_valid[scan_idx]) begin
        xfer    = 1'b1;
        win_idx = scan_idx;
      end
    end
    if (xfer) grant[win_idx] = 1'b1;
  end

  assign win_addr = addr_arr[win_idx];
  assign win_data = data_arr[win_idx];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (int'(win_idx) == NREQ - 1) ? ptr_t'(0) : win_idx + ptr_t'(1);
    rf_we_d = xfer && (win_addr != 5'd0);
    rf_wa_d = xfer ? win_addr : rf_wa_q;
    rf_wd_d = xfer ? win_data : rf_wd_q;
  end

  assign issue_ready = (bus.issue_rd == 5'd0) || !busy_q[bus.issue_rd];

  // Set is OR-ed after the clear so a same-edge reservation survives.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.issue_valid && issue_ready && (bus.issue_rd != 5'd0)) set_vec[bus.issue_rd] = 1'b1;
`ifdef WB_FORWARD_EN
    if (xfer && (win_addr != 5'd0)) clr_vec[win_addr] = 1'b1;
`else
    if (rf_we_q) clr_vec[rf_wa_q] = 1'b1;
`endif
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rf_we_q  <= rf_we_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_wa       = rf_wa_q;
  assign bus.rf_wd       = rf_wd_q;
  assign bus.issue_ready = issue_ready;
  assign bus.busy_a      = (bus.ra_a != 5'd0) && busy_q[bus.ra_a];
  assign bus.busy_b      = (bus.ra_b != 5'd0) && busy_q[bus.ra_b];

`ifdef WB_FORWARD_EN
  assign bus.fwd_hit_a = rf_we_q && (rf_wa_q == bus.ra_a) && (bus.ra_a != 5'd0);
  assign bus.fwd_hit_b = rf_we_q && (rf_wa_q == bus.ra_b) && (bus.ra_b != 5'd0);
  assign bus.fwd_data  = rf_wd_q;
`else
  assign bus.fwd_hit_a = 1'b0;
  assign bus.fwd_hit_b = 1'b0;
  assign bus.fwd_data  = 32'd0;
`endif
endmodule
